// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter sharing the ROM/scratch memory bus, with requester lock for multi-word sequences.
// Define ARB_LOCK_TIMEOUT_EN to force-release a lock idle for LOCK_MAX cycles (pulses lock_err).
module rom_bus_arbiter #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_we,
   input  logic [NUM_REQ-1:0]   req_lock,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   inout  wire  [31:0]          mem_data,
   output logic [2:0]           arb_owner,
   output logic                 arb_busy,
   output logic                 lock_err
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Supported range: 2..8 requesters, lock limit must fit the 5-bit idle counter.
   if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX < 1 || LOCK_MAX > 31) begin : g_unsupported_params
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_LOCKED} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               we_q, we_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;

   logic               any_req;
   logic [IDX_W-1:0]   winner, cand, sel, next_ptr;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               load, lock_eff, timeout;

   assign next_ptr     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign owner_onehot = NUM_REQ'(1) << owner_q;

   always_comb begin
      any_req = 1'b0;
      winner  = rr_ptr_q;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!any_req && req_valid[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

`ifdef ARB_LOCK_TIMEOUT_EN
   logic [4:0]       idle_cnt_q, idle_cnt_d;
   logic             blk_q, blk_d;
   logic [IDX_W-1:0] blk_idx_q;
   logic             lock_err_q;

   // A timed-out owner may not relock until its req_lock has been seen low.
   assign lock_eff = req_lock[owner_q] && !(blk_q && (blk_idx_q == owner_q));

   always_comb begin
      idle_cnt_d = '0;
      timeout    = 1'b0;
      blk_d      = blk_q;
      if (blk_q && !req_lock[blk_idx_q]) blk_d = 1'b0;
      if (state_q == ST_LOCKED && !req_valid[owner_q] && req_lock[owner_q]) begin
         idle_cnt_d = idle_cnt_q + 5'd1;
         if (idle_cnt_d == 5'(LOCK_MAX)) begin
            timeout = 1'b1;
            blk_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt_q <= '0;
         blk_q      <= 1'b0;
         blk_idx_q  <= '0;
         lock_err_q <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         blk_q      <= blk_d;
         lock_err_q <= timeout;
         if (timeout) blk_idx_q <= owner_q;
      end
   end

   assign lock_err = lock_err_q;
`else
   assign lock_eff = req_lock[owner_q];
   assign timeout  = 1'b0;
   assign lock_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      load        = 1'b0;
      sel         = owner_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               sel     = winner;
               load    = 1'b1;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            rr_ptr_d = next_ptr;
            if (!we_q) begin
               rsp_valid_d = owner_onehot;
               rsp_rdata_d = mem_data;
            end
            state_d = lock_eff ? ST_LOCKED : ST_IDLE;
         end
         ST_LOCKED: begin
            if (req_valid[owner_q]) begin
               load    = 1'b1;
               state_d = ST_ACCESS;
            end else if (!req_lock[owner_q] || timeout) begin
               state_d = ST_IDLE;
               if (timeout) rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         owner_d = sel;
         we_d    = req_we[sel];
         addr_d  = req_addr[{sel, 5'd0} +: 32];
         wdata_d = req_wdata[{sel, 5'd0} +: 32];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // The memory owns mem_data whenever mem_we is low.
   assign mem_data  = (state_q == ST_ACCESS && we_q) ? wdata_q : 'z;
   assign mem_we    = (state_q == ST_ACCESS) && we_q;
   assign mem_addr  = addr_q;
   assign req_ready = (state_q == ST_ACCESS) ? owner_onehot : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign arb_owner = 3'(owner_q);
   assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Self-checking bench for rom_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_rom_bus_arbiter;

   localparam int NUM_REQ  = 3;
   localparam int LOCK_MAX = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid, req_we, req_lock;
   logic [NUM_REQ*32-1:0] req_addr, req_wdata;
   logic [NUM_REQ-1:0]    req_ready, rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   wire  [31:0]           mem_data;
   logic [2:0]            arb_owner;
   logic                  arb_busy, lock_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;

   rom_bus_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .arb_owner(arb_owner), .arb_busy(arb_busy), .lock_err(lock_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Bench-side memory: 256 words at FFFFC000, drives the bus whenever mem_we is low.
   logic [31:0] mem_arr [256];
   logic [31:0] ref_mem [256];
   assign mem_data = mem_we ? 32'bz : mem_arr[mem_addr[9:2]];
   always @(posedge clk) if (rst && mem_we) mem_arr[mem_addr[9:2]] <= mem_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_cnt);
      end
   endtask

   // Reference model: one grant per free cycle by round-robin, each grant followed by a one-cycle access.
   int                 m_acc, m_ao, m_lo, m_rr, m_owner, m_idle;
   logic               m_awe, m_lkerr;
   logic [31:0]        m_aaddr, m_awdata, m_rsp_d;
   logic [NUM_REQ-1:0] m_rsp_v, exp_r;
   bit                 m_blk [NUM_REQ];

   task automatic grant(input int j);
      m_acc   = 1;
      m_ao    = j;
      m_owner = j;
      m_lo    = -1;
      m_awe   = req_we[j];
      m_aaddr = req_addr[32*j +: 32];
      m_awdata = req_wdata[32*j +: 32];
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_acc = 0; m_lo = -1; m_rr = 0; m_owner = 0; m_idle = 0;
         m_rsp_v = '0; m_rsp_d = '0; m_lkerr = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) m_blk[i] = 0;
      end else begin
         exp_r = (m_acc != 0) ? (NUM_REQ'(1) << m_ao) : '0;
         check("ready", 32'(req_ready), 32'(exp_r));
         check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
         if (m_rsp_v != 0) check("rsp_rdata", rsp_rdata, m_rsp_d);
         check("busy", 32'(arb_busy), 32'(m_acc != 0 || m_lo >= 0));
         check("owner", 32'(arb_owner), 32'(m_owner));
         check("mem_we", 32'(mem_we), 32'(m_acc != 0 && m_awe));
         check("lock_err", 32'(lock_err), 32'(m_lkerr));
         if (m_acc != 0) begin
            check("mem_addr", mem_addr, m_aaddr);
            if (m_awe) check("mem_wdata", mem_data, m_awdata);
         end
         m_rsp_v = '0;
         m_lkerr = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) if (!req_lock[i]) m_blk[i] = 0;
         if (m_acc != 0) begin
            m_rr = (m_ao + 1) % NUM_REQ;
            if (m_awe) ref_mem[m_aaddr[9:2]] = m_awdata;
            else begin
               m_rsp_v = NUM_REQ'(1) << m_ao;
               m_rsp_d = ref_mem[m_aaddr[9:2]];
            end
            m_acc  = 0;
            m_idle = 0;
            m_lo   = (req_lock[m_ao] && !m_blk[m_ao]) ? m_ao : -1;
         end else if (m_lo >= 0) begin
            if (req_valid[m_lo]) grant(m_lo);
            else if (!req_lock[m_lo]) m_lo = -1;
`ifdef ARB_LOCK_TIMEOUT_EN
            else begin
               m_idle++;
               if (m_idle == LOCK_MAX) begin
                  m_blk[m_lo] = 1;
                  m_lo        = -1;
                  m_lkerr     = 1'b1;
               end
            end
`endif
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (m_acc == 0 && req_valid[(m_rr + k) % NUM_REQ]) grant((m_rr + k) % NUM_REQ);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_lock[i]  = lk;
      req_addr[32*i +: 32]  = a;
      req_wdata[32*i +: 32] = d;
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_reqs();
      repeat (2) cyc();
      rst = 1'b1;
   endtask

   task automatic wait_ready(input int i, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         if (req_ready[i]) begin
            at = cyc_cnt;
            return;
         end
         cyc();
      end
      check($sformatf("ready%0d_timeout", i), 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int t, t0, t1, order[$], at[$];
      logic [NUM_REQ-1:0] rdy_prev;
      bit seen;

      rst = 1'b0;
      clear_reqs();
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 32'h5A00_0000 + 32'(i * 7);
         ref_mem[i] = 32'h5A00_0000 + 32'(i * 7);
      end
      mem_arr[8'h40] = 32'h0000_0001;
      ref_mem[8'h40] = 32'h0000_0001;
      repeat (2) cyc();

      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_owner", 32'(arb_owner), 32'd0);
      check("rst_busy", 32'(arb_busy), 32'd0);
      check("rst_lock_err", 32'(lock_err), 32'd0);
      rst = 1'b1;
      cyc();

      // Single read of FFFFC100
      set_req(0, 1'b0, 32'hFFFF_C100, 32'h0, 1'b0);
      wait_ready(0, t);
      check("rd_mem_we", 32'(mem_we), 32'd0);
      check("rd_bus", mem_data, 32'h0000_0001);
      cyc();
      req_valid[0] = 1'b0;
      check("rd_rsp_valid", 32'(rsp_valid), 32'b001);
      check("rd_rsp_rdata", rsp_rdata, 32'h0000_0001);

      // Write then read back by requester 1
      set_req(1, 1'b1, 32'hFFFF_C084, 32'hDEAD_BEEF, 1'b0);
      wait_ready(1, t);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_bus", mem_data, 32'hDEAD_BEEF);
      cyc();
      check("wr_no_rsp", 32'(rsp_valid), 32'd0);
      set_req(1, 1'b0, 32'hFFFF_C084, 32'h0, 1'b0);
      wait_ready(1, t);
      cyc();
      req_valid[1] = 1'b0;
      check("wr_rd_rsp_valid", 32'(rsp_valid), 32'b010);
      check("wr_rd_rdata", rsp_rdata, 32'hDEAD_BEEF);

      // Continuous contention from rr_ptr=0
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'hFFFF_C000 + 32'(i * 4), 32'h0, 1'b0);
      for (int k = 0; k < 16 && order.size() < 6; k++) begin
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) begin
            order.push_back(i);
            at.push_back(cyc_cnt);
         end
         cyc();
      end
      check("cont_grants", 32'(order.size()), 32'd6);
      for (int g = 0; g < order.size(); g++) begin
         check($sformatf("cont_order%0d", g), 32'(order[g]), 32'(g % 3));
         if (g > 0) check($sformatf("cont_gap%0d", g), 32'(at[g] - at[g-1]), 32'd2);
      end
      clear_reqs();
      repeat (3) cyc();

      // Locked 4-word write by requester 2 while requester 0 waits
      do_reset();
      set_req(2, 1'b1, 32'hFFFF_C004, $urandom, 1'b1);
      cyc();
      set_req(0, 1'b0, 32'hFFFF_C200, 32'h0, 1'b0);
      for (int w = 0; w < 4; w++) begin
         wait_ready(2, t);
         cyc();
         if (w < 3) set_req(2, 1'b1, 32'hFFFF_C004 + 32'((w + 1) * 4), $urandom, 1'b1);
         else req_valid[2] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         check("lock_hold_req0", 32'(req_ready[0]), 32'd0);
         check("lock_hold_busy", 32'(arb_busy), 32'd1);
         cyc();
      end
      req_lock[2] = 1'b0;
      t0 = cyc_cnt;
      wait_ready(0, t1);
      check("lock_release_latency", 32'(t1 - t0), 32'd2);
      cyc();
      clear_reqs();
      repeat (3) cyc();

      // Random traffic
      rdy_prev = '0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && rdy_prev[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0)
                  set_req(i, 1'($urandom_range(0, 1)),
                          32'hFFFF_C000 | (32'($urandom_range(0, 255)) << 2),
                          $urandom, 1'($urandom_range(0, 3) == 0));
               else if (req_lock[i] && $urandom_range(0, 2) == 0)
                  req_lock[i] = 1'b0;
            end
         end
         rdy_prev = req_ready;
         cyc();
      end
      for (int k = 0; k < 40 && (req_valid != 0 || arb_busy); k++) begin
         for (int i = 0; i < NUM_REQ; i++) if (rdy_prev[i]) req_valid[i] = 1'b0;
         req_lock = '0;
         rdy_prev = req_ready;
         cyc();
      end
      clear_reqs();
      repeat (3) cyc();

      // Reset asserted during an ACCESS cycle
      set_req(1, 1'b0, 32'hFFFF_C010, 32'h0, 1'b0);
      wait_ready(1, t);
      cyc();
      req_valid[1] = 1'b0;
      set_req(2, 1'b1, 32'hFFFF_C3F0, 32'h1234_5678, 1'b0);
      wait_ready(2, t);
      rst = 1'b0;
      #1;
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_busy", 32'(arb_busy), 32'd0);
      check("midrst_owner", 32'(arb_owner), 32'd0);
      clear_reqs();
      cyc();
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      set_req(1, 1'b0, 32'hFFFF_C020, 32'h0, 1'b0);
      set_req(2, 1'b0, 32'hFFFF_C024, 32'h0, 1'b0);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (req_ready != 0) begin
            check("midrst_rr_restart", 32'(req_ready), 32'b010);
            seen = 1;
         end else cyc();
      end
      if (!seen) check("midrst_grant_timeout", 32'd0, 32'd1);
      clear_reqs();
      repeat (6) cyc();

`ifdef ARB_LOCK_TIMEOUT_EN
      // Idle lock is force-released after LOCK_MAX cycles
      do_reset();
      set_req(2, 1'b0, 32'hFFFF_C030, 32'h0, 1'b1);
      wait_ready(2, t);
      cyc();
      req_valid[2] = 1'b0;
      set_req(0, 1'b0, 32'hFFFF_C034, 32'h0, 1'b0);
      t0 = cyc_cnt;
      t1 = -1;
      for (int k = 0; k < 30 && t1 < 0; k++) begin
         if (lock_err) t1 = cyc_cnt;
         else cyc();
      end
      check("tmo_lock_err_at", 32'(t1 - t0), 32'(LOCK_MAX));
      check("tmo_idle", 32'(arb_busy), 32'd0);
      cyc();
      check("tmo_req0_granted", 32'(req_ready), 32'b001);
      check("tmo_lock_err_pulse", 32'(lock_err), 32'd0);
      cyc();
      clear_reqs();
      repeat (4) cyc();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_bus_arbiter.md
Name: rom_bus_arbiter

Overview:
- Round-robin arbiter that shares the embedded ROM/scratch memory bus (mem_we, mem_addr, tristate mem_data) among NUM_REQ requesters, e.g. core fetch, core data and debug loader.
- Issues one bus access at a time and sequences the shared inout data line.
- Supports a lock so one requester can own the bus for multi-word sequences, such as GPR-window save/restore.
- Sits between the requesters and the memory peripheral.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- LOCK_MAX, 16, idle cycles allowed in LOCKED before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  keep ownership after the current access.
- req_addr  in  NUM_REQ*32  byte address; requester i uses bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  write data, same packing as req_addr.
- req_ready  out  NUM_REQ  one-cycle pulse: access performed.
- rsp_valid  out  NUM_REQ  one-cycle pulse: read data valid on rsp_rdata.
- rsp_rdata  out  32  read data, shared by all requesters.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_data  inout  32  memory data.
- arb_owner  out  3  index of the current or last owner.
- arb_busy  out  1  state != IDLE.
- lock_err  out  1  forced lock release pulse (optional feature only).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rr_ptr=0, arb_owner=0.
  - mem_we=0, mem_addr=0, mem_data=Z.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, lock_err=0.
  - Reset mid-access aborts the access with no ready or rsp pulse.
- Request rules:
  - A requester holds req_valid, req_we, req_addr and req_wdata stable until its req_ready pulse.
  - Dropping req_valid before ready is illegal and gives undefined behaviour.
- FSM states:
  - IDLE: if any req_valid, select the winner by round-robin search starting at rr_ptr (lowest index at or after rr_ptr, wrapping). Register the winner's we/addr/wdata onto the bus, arb_owner=winner, go to ACCESS. If no request, stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - mem_we and mem_addr are driven from registers.
    - mem_data is driven with wdata only when mem_we=1, otherwise Z. The arbiter never drives mem_data while mem_we=0, because the memory drives the line during reads.
    - req_ready[owner] pulses high.
    - For a read, mem_data is sampled at the end of the cycle; rsp_rdata is updated and rsp_valid[owner] pulses in the next cycle.
    - rr_ptr = (owner+1) mod NUM_REQ.
    - Next state: if req_lock[owner]=1, go to LOCKED; otherwise go to IDLE.
  - LOCKED:
    - Bus idle: mem_we=0, mem_data=Z, mem_addr holds its last value.
    - If req_valid[owner], register that request and go to ACCESS with no arbitration.
    - Else if req_lock[owner]=0, go to IDLE.
    - Other requesters are ignored while LOCKED.
- Timing:
  - Read latency: request seen in IDLE (cycle 0), ACCESS (cycle 1, ready), rsp_valid (cycle 2).
  - Unlocked throughput: 1 access per 2 cycles.
  - Locked back-to-back throughput: 1 access per 2 cycles (ACCESS, LOCKED, ACCESS).
- Simultaneous requests: exactly one grant per arbitration.
- Fairness: under continuous contention, every requester is granted within NUM_REQ arbitrations unless a lock is held.
- Write access: no rsp_valid pulse.
- arb_owner holds its value in IDLE.

Optional Feature:
- Macro: ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A 5-bit idle counter runs in LOCKED. It clears on entry and on every owner access, and increments each LOCKED cycle without req_valid[owner].
  - When the count reaches LOCK_MAX: force state=IDLE, pulse lock_err for 1 cycle, set rr_ptr=(owner+1) mod NUM_REQ.
  - The owner must drop req_lock and then re-assert it to lock again; a held req_lock does not relock until it has been seen low.
- Undefined: lock_err is tied 0, no counter exists, and a lock is held indefinitely.

Test Plan:
- Single read: req0 read addr FFFFC100 -> ACCESS cycle with mem_we=0 and mem_data not driven by the arbiter; rsp_valid[0] one cycle later with rsp_rdata=00000001.
- Write then read: req1 writes FFFFC084=DEADBEEF, then reads it -> no rsp on the write; rsp_rdata=DEADBEEF on the read; mem_data driven only in the write ACCESS cycle.
- Contention: req0, req1 and req2 valid continuously from rr_ptr=0 -> grant order 0,1,2,0,1,2; each ready pulse 2 cycles apart.
- Lock: req2 with req_lock writes 4 words to FFFFC004..FFFFC010 while req0 stays valid -> req0 is not granted until req2 drops req_lock; req0 is then granted within 2 cycles.
- Reset mid-access: assert rst low during ACCESS -> bus outputs return to reset values immediately, no ready/rsp pulses, rr_ptr=0 after release.
- Timeout (ARB_LOCK_TIMEOUT_EN, LOCK_MAX=16): owner holds req_lock with no requests for 16 cycles -> lock_err pulse, state IDLE, a pending req0 is granted next.
